// File: rtl/spiflash_responder.sv
// SPI NOR flash responder (mode 0) serving reads from an on-chip memory port.
// Supports READ (0x03), FAST_READ (0x0B) and JEDEC ID (0x9F); other commands are ignored.
// The SPI pins are oversampled on clk25. ADDR_W is expected to be at most 24.
module spiflash_responder #(
  parameter int unsigned ADDR_W       = 24,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4018,
  parameter int unsigned DUMMY_CYCLES = 8
) (
  input  logic              clk25,
  input  logic              reset_btn,
  input  logic              flash_csn,
  input  logic              flash_sck,
  input  logic              flash_mosi,
  output logic              flash_miso,
  output logic              flash_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {StCmd, StAddr, StDummy, StFetch, StData, StId, StIgnore} state_e;

  logic [1:0] csn_sync;
  logic [2:0] sck_sync;
  logic [1:0] mosi_sync;
  logic       csn_s, sck_s, sck_d, mosi_s, rise, fall;

  state_e              state_q, state_d;
  logic [7:0]          bit_cnt_q, bit_cnt_d;
  logic [23:0]         shift_q, shift_d, shift_next;
  logic [7:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                fetch_ph_q, fetch_ph_d;
  logic [7:0]          tx_q, tx_d;
  logic [7:0]          pf_q, pf_d;
  logic                pf_cap_q, pf_cap_d;
  logic                started_q, started_d;
  logic [2:0]          out_idx_q, out_idx_d;
  logic                miso_q, miso_d;
  logic                oe_q, oe_d;
  logic                mem_rd_c;

  // Synchronize the asynchronous SPI pins; csn resets to the deselected level.
  always_ff @(posedge clk25 or negedge reset_btn) begin
    if (!reset_btn) begin
      csn_sync  <= 2'b11;
      sck_sync  <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      csn_sync  <= {csn_sync[0], flash_csn};
      sck_sync  <= {sck_sync[1:0], flash_sck};
      mosi_sync <= {mosi_sync[0], flash_mosi};
    end
  end

  assign csn_s  = csn_sync[1];
  assign sck_s  = sck_sync[1];
  assign sck_d  = sck_sync[2];
  assign mosi_s = mosi_sync[1];
  assign rise   = sck_s & ~sck_d & ~csn_s;
  assign fall   = ~sck_s & sck_d & ~csn_s;

  // Protocol state register.
  always_ff @(posedge clk25 or negedge reset_btn) begin
    if (!reset_btn) begin
      state_q    <= StCmd;
      bit_cnt_q  <= 8'd0;
      shift_q    <= 24'd0;
      cmd_q      <= 8'd0;
      addr_q     <= '0;
      fetch_ph_q <= 1'b0;
      tx_q       <= 8'd0;
      pf_q       <= 8'd0;
      pf_cap_q   <= 1'b0;
      started_q  <= 1'b0;
      out_idx_q  <= 3'd0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      fetch_ph_q <= fetch_ph_d;
      tx_q       <= tx_d;
      pf_q       <= pf_d;
      pf_cap_q   <= pf_cap_d;
      started_q  <= started_d;
      out_idx_q  <= out_idx_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
    end
  end

  // Next-state logic: command/address shifting, memory fetches and MISO sequencing.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    fetch_ph_d = fetch_ph_q;
    tx_d       = tx_q;
    pf_d       = pf_q;
    pf_cap_d   = pf_cap_q;
    started_d  = started_q;
    out_idx_d  = out_idx_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    mem_rd_c   = 1'b0;
    shift_next = {shift_q[22:0], mosi_s};

    if (csn_s) begin
      // Deselect aborts everything, including any partial byte.
      state_d    = StCmd;
      bit_cnt_d  = 8'd0;
      fetch_ph_d = 1'b0;
      pf_cap_d   = 1'b0;
      started_d  = 1'b0;
      miso_d     = 1'b0;
      oe_d       = 1'b0;
    end else begin
      // Prefetched byte arrives one cycle after its read strobe.
      if (pf_cap_q) begin
        pf_d     = mem_rdata;
        addr_d   = addr_q + 1'b1;
        pf_cap_d = 1'b0;
      end
      unique case (state_q)
        StCmd: begin
          if (rise) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + 8'd1;
            if (bit_cnt_q == 8'd7) begin
              bit_cnt_d = 8'd0;
              cmd_d     = shift_next[7:0];
              case (shift_next[7:0])
                8'h03, 8'h0B: state_d = StAddr;
                8'h9F: begin
                  state_d = StId;
                  shift_d = JEDEC_ID;
                end
                default: state_d = StIgnore;
              endcase
            end
          end
        end
        StAddr: begin
          if (rise) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + 8'd1;
            if (bit_cnt_q == 8'd23) begin
              bit_cnt_d = 8'd0;
              addr_d    = shift_next[ADDR_W-1:0];
              if (cmd_q == 8'h0B && DUMMY_CYCLES != 0) state_d = StDummy;
              else                                     state_d = StFetch;
            end
          end
        end
        StDummy: begin
          if (rise) begin
            bit_cnt_d = bit_cnt_q + 8'd1;
            if (bit_cnt_q == 8'(DUMMY_CYCLES - 1)) begin
              bit_cnt_d = 8'd0;
              state_d   = StFetch;
            end
          end
        end
        StFetch: begin
          if (!fetch_ph_q) begin
            mem_rd_c   = 1'b1;
            fetch_ph_d = 1'b1;
          end else begin
            tx_d       = mem_rdata;
            addr_d     = addr_q + 1'b1;
            fetch_ph_d = 1'b0;
            started_d  = 1'b0;
            state_d    = StData;
          end
        end
        StData: begin
          if (fall) begin
            oe_d      = 1'b1;
            started_d = 1'b1;
            out_idx_d = 3'd7;
            if (!started_q) begin
              miso_d = tx_q[7];
            end else if (out_idx_q == 3'd0) begin
              tx_d   = pf_q;
              miso_d = pf_q[7];
            end else begin
              miso_d    = tx_q[3'(out_idx_q - 3'd1)];
              out_idx_d = 3'(out_idx_q - 3'd1);
            end
          end else if (rise && started_q && out_idx_q == 3'd7) begin
            // Initiator is sampling bit 7: fetch the following byte now.
            mem_rd_c = 1'b1;
            pf_cap_d = 1'b1;
          end
        end
        StId: begin
          // Zeros shift in behind the ID, so it reads 0 once exhausted.
          if (fall) begin
            miso_d  = shift_q[23];
            oe_d    = 1'b1;
            shift_d = {shift_q[22:0], 1'b0};
          end
        end
        StIgnore: oe_d = 1'b0;
        default:  state_d = StCmd;
      endcase
    end
  end

  assign flash_miso    = miso_q;
  assign flash_miso_oe = oe_q & ~csn_s;
  assign mem_addr      = addr_q;
  assign mem_rd        = mem_rd_c;
  assign busy          = ~csn_s;

endmodule

// File: tb/tb_spiflash_responder.sv
// Bench for spiflash_responder: table of SPI transactions plus hand-written
// reset, abort, unknown-command and 8-bit address wrap sequences.
module tb_spiflash_responder;

  logic        clk25 = 1'b0;
  logic        reset_btn, csn, sck, mosi;
  logic        miso, oe, mem_rd, busy;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        miso8, oe8, mem_rd8, busy8;
  logic [7:0]  mem_addr8, mem_rdata8;

  logic [7:0]  mem [0:4095];
  logic [23:0] exp_q[$];
  logic [7:0]  exp8_q[$];
  logic        watch8 = 1'b0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          nbytes;
    logic [31:0] exp;
    int          n_rd;
  } vec_t;
  vec_t vecs [4];

  always #5 clk25 = ~clk25;

  spiflash_responder dut (
    .clk25(clk25), .reset_btn(reset_btn), .flash_csn(csn), .flash_sck(sck),
    .flash_mosi(mosi), .flash_miso(miso), .flash_miso_oe(oe), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .busy(busy)
  );

  spiflash_responder #(.ADDR_W(8)) dut8 (
    .clk25(clk25), .reset_btn(reset_btn), .flash_csn(csn), .flash_sck(sck),
    .flash_mosi(mosi), .flash_miso(miso8), .flash_miso_oe(oe8), .mem_addr(mem_addr8),
    .mem_rd(mem_rd8), .mem_rdata(mem_rdata8), .busy(busy8)
  );

  // Memory models: data valid one cycle after the read strobe.
  always @(posedge clk25) begin
    if (mem_rd)  mem_rdata  <= mem[mem_addr[11:0]];
    if (mem_rd8) mem_rdata8 <= mem[{4'h0, mem_addr8}];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every read strobe must match the next expected address.
  always @(negedge clk25) begin
    if (reset_btn && mem_rd) begin
      if (exp_q.size() == 0) chk("rd_unexpected", {8'h0, mem_addr}, 32'hFFFF_FFFF);
      else                   chk("rd_addr", {8'h0, mem_addr}, {8'h0, exp_q.pop_front()});
    end
    if (reset_btn && mem_rd8 && watch8) begin
      if (exp8_q.size() == 0) chk("rd8_unexpected", {24'h0, mem_addr8}, 32'hFFFF_FFFF);
      else                    chk("rd8_addr", {24'h0, mem_addr8}, {24'h0, exp8_q.pop_front()});
    end
  end

  task automatic half();
    repeat (6) @(posedge clk25);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] rx8,
                      output logic oe_all, output logic oe_any);
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      half();
      sck    = 1'b1;
      rx[i]  = miso;
      rx8[i] = miso8;
      oe_all = oe_all & oe;
      oe_any = oe_any | oe;
      half();
      sck = 1'b0;
    end
  endtask

  task automatic begin_tx();
    csn = 1'b0;
    half();
    chk("busy_on", {31'h0, busy}, 32'h1);
  endtask

  task automatic end_tx();
    half();
    csn = 1'b1;
    half();
    chk("busy_off", {31'h0, busy}, 32'h0);
    chk("oe_off", {31'h0, oe}, 32'h0);
    half();
    chk("rd_pending", exp_q.size(), 32'h0);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] r, r8;
    logic       oa, on;
    xfer(a[23:16], r, r8, oa, on);
    xfer(a[15:8], r, r8, oa, on);
    xfer(a[7:0], r, r8, oa, on);
  endtask

  initial begin
    logic [7:0] rx, rx8, eb;
    logic       oe_all, oe_any;

    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    mem[12'h010] = 8'hA5; mem[12'h011] = 8'h3C; mem[12'h012] = 8'hFF;
    mem[12'h100] = 8'h81; mem[12'h020] = 8'h5A; mem[12'h021] = 8'h00;
    mem[12'h000] = 8'hC3; mem[12'h0FF] = 8'h6E;

    vecs[0] = '{cmd: 8'h03, addr: 24'h000010, nbytes: 3, exp: 32'hA53CFF00, n_rd: 4};
    vecs[1] = '{cmd: 8'h0B, addr: 24'h000100, nbytes: 1, exp: 32'h81000000, n_rd: 2};
    vecs[2] = '{cmd: 8'h9F, addr: 24'h000000, nbytes: 4, exp: 32'hEF401800, n_rd: 0};
    vecs[3] = '{cmd: 8'h03, addr: 24'h000020, nbytes: 2, exp: 32'h5A000000, n_rd: 3};

    reset_btn = 1'b0; csn = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (4) @(posedge clk25);
    #1;
    chk("rst_miso", {31'h0, miso}, 32'h0);
    chk("rst_oe", {31'h0, oe}, 32'h0);
    chk("rst_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_addr", {8'h0, mem_addr}, 32'h0);
    reset_btn = 1'b1;
    half();

    // Reset asserted in the middle of a data byte.
    begin_tx();
    exp_q.push_back(24'h000040);
    exp_q.push_back(24'h000041);
    xfer(8'h03, rx, rx8, oe_all, oe_any);
    send_addr(24'h000040);
    for (int i = 0; i < 4; i++) begin
      half(); sck = 1'b1; half(); sck = 1'b0;
    end
    half();
    chk("mid_oe_on", {31'h0, oe}, 32'h1);
    reset_btn = 1'b0;
    #1;
    chk("mid_rst_miso", {31'h0, miso}, 32'h0);
    chk("mid_rst_oe", {31'h0, oe}, 32'h0);
    chk("mid_rst_rd", {31'h0, mem_rd}, 32'h0);
    csn = 1'b1;
    half();
    reset_btn = 1'b1;
    half();
    chk("rd_pending", exp_q.size(), 32'h0);

    for (int v = 0; v < 4; v++) begin
      begin_tx();
      for (int k = 0; k < vecs[v].n_rd; k++) exp_q.push_back(vecs[v].addr + 24'(k));
      xfer(vecs[v].cmd, rx, rx8, oe_all, oe_any);
      if (vecs[v].cmd != 8'h9F) send_addr(vecs[v].addr);
      if (vecs[v].cmd == 8'h0B) begin
        xfer(8'h00, rx, rx8, oe_all, oe_any);
        chk($sformatf("v%0d_dummy_oe", v), {31'h0, oe_any}, 32'h0);
      end
      for (int b = 0; b < vecs[v].nbytes; b++) begin
        xfer(8'h00, rx, rx8, oe_all, oe_any);
        eb = vecs[v].exp[31 - 8 * b -: 8];
        chk($sformatf("v%0d_byte%0d", v, b), {24'h0, rx}, {24'h0, eb});
        chk($sformatf("v%0d_oe%0d", v, b), {31'h0, oe_all}, 32'h1);
      end
      end_tx();
    end

    // Abort after 12 address bits, then a clean read from address 0.
    begin_tx();
    xfer(8'h03, rx, rx8, oe_all, oe_any);
    for (int i = 0; i < 12; i++) begin
      mosi = 1'b1; half(); sck = 1'b1; half(); sck = 1'b0;
    end
    end_tx();
    begin_tx();
    exp_q.push_back(24'h000000);
    exp_q.push_back(24'h000001);
    xfer(8'h03, rx, rx8, oe_all, oe_any);
    send_addr(24'h000000);
    xfer(8'h00, rx, rx8, oe_all, oe_any);
    chk("abort_byte", {24'h0, rx}, 32'hC3);
    end_tx();

    // Unknown command: no output enable, no memory reads.
    begin_tx();
    xfer(8'h05, rx, rx8, oe_all, oe_any);
    for (int i = 0; i < 3; i++) begin
      xfer(8'hFF, rx, rx8, oe_all, oe_any);
      chk($sformatf("unk_oe%0d", i), {31'h0, oe_any}, 32'h0);
    end
    end_tx();

    // Wrap: the 8-bit instance must roll 0xFF over to 0x00.
    watch8 = 1'b1;
    begin_tx();
    exp_q.push_back(24'h0000FF);
    exp_q.push_back(24'h000100);
    exp_q.push_back(24'h000101);
    exp8_q.push_back(8'hFF);
    exp8_q.push_back(8'h00);
    exp8_q.push_back(8'h01);
    xfer(8'h03, rx, rx8, oe_all, oe_any);
    send_addr(24'h0000FF);
    xfer(8'h00, rx, rx8, oe_all, oe_any);
    chk("wrap_byte0", {24'h0, rx8}, 32'h6E);
    xfer(8'h00, rx, rx8, oe_all, oe_any);
    chk("wrap_byte1", {24'h0, rx8}, 32'hC3);
    end_tx();
    chk("rd8_pending", exp8_q.size(), 32'h0);
    watch8 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
